// File: rtl/frame_config_loader.sv
// frame_config_loader
//   Loads configuration frames into a column of frame-latched tiles. A header
//   word (sync 0xA5, start frame S, count N) opens a transfer, then N data
//   words are each presented on FrameData with one cycle of setup, a single
//   strobe cycle on FrameStrobe[idx] and one cycle of hold.
//
//   state  | meaning
//   IDLE   | waiting for a header word, WordReady high
//   LOAD   | waiting for the next data word, WordReady high
//   SETUP  | FrameData settling ahead of the strobe
//   STROBE | FrameStrobe[idx] high for one cycle
//   HOLD   | FrameData held after the strobe, advance idx/remaining
//   ERR    | bad header seen, only Reset leaves
//
// Ports
//   UserCLK     clock, rising edge
//   Reset       synchronous active-high reset
//   WordIn      header or frame data word
//   WordValid   WordIn valid
//   WordReady   loader accepts WordIn this cycle
//   FrameData   data presented to the frame latches
//   FrameStrobe one-hot latch enable
//   Busy        transfer in progress
//   Done        one-cycle pulse after the last frame of a transfer
//   Error       sticky header error flag
module frame_config_loader #(
    parameter int MaxFramesPerCol = 20
) (
    input  logic                       UserCLK,
    input  logic                       Reset,
    input  logic [31:0]                WordIn,
    input  logic                       WordValid,
    output logic                       WordReady,
    output logic [31:0]                FrameData,
    output logic [MaxFramesPerCol-1:0] FrameStrobe,
    output logic                       Busy,
    output logic                       Done,
    output logic                       Error
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD,
        ST_ERR
    } state_t;

    state_t                     state_q, state_d;
    logic [7:0]                 idx_q, idx_d;
    logic [7:0]                 rem_q, rem_d;
    logic [31:0]                frame_data_q, frame_data_d;
    logic [MaxFramesPerCol-1:0] strobe_q, strobe_d;
    logic                       ready_q, ready_d;
    logic                       busy_q, busy_d;
    logic                       done_q, done_d;
    logic                       error_q, error_d;

    logic       accept;
    logic [7:0] hdr_sync;
    logic [7:0] hdr_start;
    logic [7:0] hdr_count;
    logic [8:0] hdr_end;
    logic       hdr_ok;

    // Handshake uses the registered ready so no input reaches an output combinationally.
    assign accept    = WordValid && ready_q;
    assign hdr_sync  = WordIn[31:24];
    assign hdr_start = WordIn[23:16];
    assign hdr_count = WordIn[15:8];
    // 9-bit sum so S + N cannot wrap past the column size.
    assign hdr_end   = {1'b0, hdr_start} + {1'b0, hdr_count};
    assign hdr_ok    = (hdr_sync == 8'hA5) && (hdr_count != 8'd0)
                       && (hdr_end <= 9'(MaxFramesPerCol));

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        rem_d        = rem_q;
        frame_data_d = frame_data_q;
        done_d       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (hdr_ok) begin
                        state_d = ST_LOAD;
                        idx_d   = hdr_start;
                        rem_d   = hdr_count;
                    end else begin
                        state_d = ST_ERR;
                    end
                end
            end
            ST_LOAD: begin
                if (accept) begin
                    frame_data_d = WordIn;
                    state_d      = ST_SETUP;
                end
            end
            ST_SETUP:  state_d = ST_STROBE;
            ST_STROBE: state_d = ST_HOLD;
            ST_HOLD: begin
                idx_d = idx_q + 8'd1;
                rem_d = rem_q - 8'd1;
                if (rem_q == 8'd1) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_ERR:  state_d = ST_ERR;
            default: state_d = ST_IDLE;
        endcase

        // Outputs are decoded from the next state so they register alongside it.
        ready_d = (state_d == ST_IDLE) || (state_d == ST_LOAD);
        busy_d  = (state_d == ST_LOAD) || (state_d == ST_SETUP)
                  || (state_d == ST_STROBE) || (state_d == ST_HOLD);
        error_d = (state_d == ST_ERR);

        strobe_d = '0;
        if (state_d == ST_STROBE) begin
            for (int i = 0; i < MaxFramesPerCol; i++) begin
                strobe_d[i] = (idx_q == 8'(i));
            end
        end
    end

    always_ff @(posedge UserCLK) begin
        if (Reset) begin
            state_q      <= ST_IDLE;
            idx_q        <= 8'd0;
            rem_q        <= 8'd0;
            frame_data_q <= 32'd0;
            strobe_q     <= '0;
            ready_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            rem_q        <= rem_d;
            frame_data_q <= frame_data_d;
            strobe_q     <= strobe_d;
            ready_q      <= ready_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
        end
    end

    assign WordReady   = ready_q;
    assign FrameData   = frame_data_q;
    assign FrameStrobe = strobe_q;
    assign Busy        = busy_q;
    assign Done        = done_q;
    assign Error       = error_q;

endmodule

// File: tb/tb_frame_config_loader.sv
// tb_frame_config_loader
//   Drives header/data words into frame_config_loader and compares strobe
//   events, FrameData and Done/Error/Busy against a transaction-level model:
//   each data word accepted at cycle D for frame S+k must strobe bit S+k at
//   D+2 with that word on FrameData from D+1 through D+3, and Done must
//   follow the last word by 4 cycles.
module tb_frame_config_loader;
    localparam int MF = 20;
    localparam int H  = 4096;

    logic          UserCLK = 1'b0;
    logic          Reset;
    logic [31:0]   WordIn;
    logic          WordValid;
    logic          WordReady;
    logic [31:0]   FrameData;
    logic [MF-1:0] FrameStrobe;
    logic          Busy;
    logic          Done;
    logic          Error;

    frame_config_loader #(.MaxFramesPerCol(MF)) dut (
        .UserCLK    (UserCLK),
        .Reset      (Reset),
        .WordIn     (WordIn),
        .WordValid  (WordValid),
        .WordReady  (WordReady),
        .FrameData  (FrameData),
        .FrameStrobe(FrameStrobe),
        .Busy       (Busy),
        .Done       (Done),
        .Error      (Error)
    );

    always #5 UserCLK = ~UserCLK;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge UserCLK) cyc++;

    // Observation log: strobe events, Done pulses, FrameData history per cycle.
    int            ev_cyc[$];
    logic [MF-1:0] ev_val[$];
    logic [31:0]   ev_data[$];
    int            done_cyc[$];
    logic [31:0]   fd_hist[H];

    always @(negedge UserCLK) begin
        fd_hist[cyc % H] = FrameData;
        if (FrameStrobe !== '0) begin
            ev_cyc.push_back(cyc);
            ev_val.push_back(FrameStrobe);
            ev_data.push_back(FrameData);
        end
        if (Done === 1'b1) done_cyc.push_back(cyc);
    end

    // Stimulus bookkeeping for the most recent transfer.
    int          xf_hdr_acc;
    int          xf_acc[$];
    logic [31:0] xf_words[$];
    bit          xf_ok;

    function automatic bit hdr_valid(input logic [31:0] h);
        return (h[31:24] == 8'hA5) && (h[15:8] != 8'd0)
               && (int'(h[23:16]) + int'(h[15:8]) <= MF);
    endfunction

    function automatic logic [31:0] mk_hdr(input logic [7:0] sync, input int s, input int n);
        logic [7:0] s8;
        logic [7:0] n8;
        s8 = 8'(s);
        n8 = 8'(n);
        return {sync, s8, n8, 8'h00};
    endfunction

    task automatic step();
        @(posedge UserCLK);
        #1;
    endtask

    task automatic clear_log();
        ev_cyc.delete();
        ev_val.delete();
        ev_data.delete();
        done_cyc.delete();
    endtask

    task automatic do_reset();
        Reset     = 1'b1;
        WordValid = 1'b0;
        step();
        Reset = 1'b0;
        step();
        clear_log();
    endtask

    // Offers w until the loader takes it (bounded); acc is the accepting cycle.
    task automatic send_word(input logic [31:0] w, output int acc, output bit ok);
        ok        = 1'b0;
        acc       = -1;
        WordIn    = w;
        WordValid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (WordReady === 1'b1) begin
                acc = cyc;
                ok  = 1'b1;
            end
            step();
            if (ok) break;
        end
        WordValid = 1'b0;
        WordIn    = $urandom;
    endtask

    task automatic xfer(input int s, input int n, input int maxgap);
        int acc;
        bit ok;
        logic [31:0] w;
        xf_acc.delete();
        xf_words.delete();
        send_word(mk_hdr(8'hA5, s, n), xf_hdr_acc, xf_ok);
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(0, maxgap)) begin
                WordIn = $urandom;
                step();
            end
            w = $urandom;
            send_word(w, acc, ok);
            xf_ok = xf_ok & ok;
            xf_acc.push_back(acc);
            xf_words.push_back(w);
        end
    endtask

    task automatic test_reset();
        Reset     = 1'b1;
        WordValid = 1'b1;
        WordIn    = mk_hdr(8'hA5, 0, 1);
        step();
        step();
        n_assert++; if (WordReady !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b want 0", WordReady); end
        n_assert++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", Busy); end
        n_assert++; if (Done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", Done); end
        n_assert++; if (Error !== 1'b0) begin n_fail++; $display("FAIL reset_error got %b want 0", Error); end
        n_assert++; if (FrameStrobe !== '0) begin n_fail++; $display("FAIL reset_strobe got %h want 0", FrameStrobe); end
        n_assert++; if (FrameData !== 32'd0) begin n_fail++; $display("FAIL reset_data got %h want 0", FrameData); end
        Reset     = 1'b0;
        WordValid = 1'b0;
        step();
        n_assert++; if (WordReady !== 1'b1) begin n_fail++; $display("FAIL reset_ready_after got %b want 1", WordReady); end
        n_assert++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy_after got %b want 0", Busy); end
        clear_log();
    endtask

    task automatic test_basic();
        int acc_h;
        int acc0;
        int acc1;
        bit ok0;
        bit ok1;
        bit ok2;
        do_reset();
        send_word(32'hA503_0200, acc_h, ok0);
        n_assert++; if (Busy !== 1'b1 || WordReady !== 1'b1) begin n_fail++; $display("FAIL basic_load_state got busy=%b ready=%b want 1 1", Busy, WordReady); end
        send_word(32'h1111_1111, acc0, ok1);
        send_word(32'h2222_2222, acc1, ok2);
        repeat (6) step();
        n_assert++; if ({ok0, ok1, ok2} !== 3'b111) begin n_fail++; $display("FAIL basic_accept got %b want 111", {ok0, ok1, ok2}); end
        n_assert++; if (acc0 !== acc_h + 1) begin n_fail++; $display("FAIL basic_first_accept got %0d want %0d", acc0, acc_h + 1); end
        n_assert++; if (acc1 !== acc0 + 4) begin n_fail++; $display("FAIL basic_throughput got %0d want %0d", acc1, acc0 + 4); end
        n_assert++; if (ev_cyc.size() !== 2) begin n_fail++; $display("FAIL basic_strobe_count got %0d want 2", ev_cyc.size()); end
        else begin
            n_assert++; if (ev_val[0] !== 20'h0_0008 || ev_data[0] !== 32'h1111_1111) begin n_fail++; $display("FAIL basic_frame0 got %h/%h want 00008/11111111", ev_val[0], ev_data[0]); end
            n_assert++; if (ev_val[1] !== 20'h0_0010 || ev_data[1] !== 32'h2222_2222) begin n_fail++; $display("FAIL basic_frame1 got %h/%h want 00010/22222222", ev_val[1], ev_data[1]); end
            n_assert++; if (ev_cyc[0] !== acc0 + 2) begin n_fail++; $display("FAIL basic_strobe_time got %0d want %0d", ev_cyc[0], acc0 + 2); end
            n_assert++; if (ev_cyc[1] - ev_cyc[0] !== 4) begin n_fail++; $display("FAIL basic_strobe_spacing got %0d want 4", ev_cyc[1] - ev_cyc[0]); end
            n_assert++; if (done_cyc.size() !== 1 || done_cyc[0] !== ev_cyc[1] + 2) begin n_fail++; $display("FAIL basic_done got n=%0d want 1 at %0d", done_cyc.size(), ev_cyc[1] + 2); end
        end
        n_assert++; if (Busy !== 1'b0 || WordReady !== 1'b1) begin n_fail++; $display("FAIL basic_idle got busy=%b ready=%b want 0 1", Busy, WordReady); end
    endtask

    task automatic test_bad_sync();
        int acc;
        bit ok;
        int bad;
        do_reset();
        send_word(32'h5A03_0200, acc, ok);
        n_assert++; if (Error !== 1'b1 || WordReady !== 1'b0 || Busy !== 1'b0) begin n_fail++; $display("FAIL badsync_flags got err=%b ready=%b busy=%b want 1 0 0", Error, WordReady, Busy); end
        bad       = 0;
        WordValid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            WordIn = (i == 0) ? 32'hA500_0100 : $urandom;
            step();
            if (WordReady !== 1'b0 || Error !== 1'b1) bad++;
        end
        WordValid = 1'b0;
        n_assert++; if (bad !== 0) begin n_fail++; $display("FAIL badsync_sticky got %0d bad cycles want 0", bad); end
        n_assert++; if (ev_cyc.size() !== 0) begin n_fail++; $display("FAIL badsync_no_strobe got %0d strobes want 0", ev_cyc.size()); end
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        step();
        n_assert++; if (Error !== 1'b0 || WordReady !== 1'b1) begin n_fail++; $display("FAIL badsync_recover got err=%b ready=%b want 0 1", Error, WordReady); end
    endtask

    // Fixed boundary headers (no gaps), then randomized transfers with gaps.
    task automatic run_cases(input string tag, input int ncase, input bit randomize_it);
        int s;
        int n;
        logic [31:0] h;
        bit v;
        for (int c = 0; c < ncase; c++) begin
            if (randomize_it) begin
                n = (c < 3) ? 5 : $urandom_range(1, 8);
                s = $urandom_range(0, MF - n);
                if (c == ncase - 1) s = $urandom_range(MF - n + 1, 255 - n);
            end else begin
                case (c)
                    0: begin s = 18; n = 3; end
                    1: begin s = 17; n = 3; end
                    2: begin s = 4;  n = 0; end
                    3: begin s = 0;  n = 20; end
                    default: begin s = 19; n = 1; end
                endcase
            end
            h = mk_hdr(8'hA5, s, n);
            v = hdr_valid(h);
            do_reset();
            if (!v) begin
                send_word(h, xf_hdr_acc, xf_ok);
                n_assert++; if (Error !== 1'b1 || Busy !== 1'b0) begin n_fail++; $display("FAIL %s_bad_hdr s=%0d n=%0d got err=%b busy=%b want 1 0", tag, s, n, Error, Busy); end
                repeat (4) step();
                n_assert++; if (ev_cyc.size() !== 0) begin n_fail++; $display("FAIL %s_bad_strobe got %0d want 0", tag, ev_cyc.size()); end
                continue;
            end
            xfer(s, n, randomize_it ? 3 : 0);
            repeat (6) step();
            n_assert++; if (xf_ok !== 1'b1 || Error !== 1'b0) begin n_fail++; $display("FAIL %s_accept s=%0d n=%0d got ok=%b err=%b want 1 0", tag, s, n, xf_ok, Error); end
            n_assert++; if (ev_cyc.size() !== n) begin n_fail++; $display("FAIL %s_strobe_count got %0d want %0d", tag, ev_cyc.size(), n); end
            for (int k = 0; k < n && k < ev_cyc.size(); k++) begin
                logic [MF-1:0] e;
                e = '0;
                e[s + k] = 1'b1;
                n_assert++; if (ev_val[k] !== e) begin n_fail++; $display("FAIL %s_strobe_bit k=%0d got %h want %h", tag, k, ev_val[k], e); end
                n_assert++; if (ev_cyc[k] !== xf_acc[k] + 2) begin n_fail++; $display("FAIL %s_strobe_time k=%0d got %0d want %0d", tag, k, ev_cyc[k], xf_acc[k] + 2); end
                n_assert++; if (ev_data[k] !== xf_words[k]) begin n_fail++; $display("FAIL %s_strobe_data k=%0d got %h want %h", tag, k, ev_data[k], xf_words[k]); end
                n_assert++; if (fd_hist[(xf_acc[k] + 1) % H] !== xf_words[k] || fd_hist[(xf_acc[k] + 3) % H] !== xf_words[k]) begin n_fail++; $display("FAIL %s_data_stable k=%0d got %h/%h want %h", tag, k, fd_hist[(xf_acc[k] + 1) % H], fd_hist[(xf_acc[k] + 3) % H], xf_words[k]); end
            end
            n_assert++; if (done_cyc.size() !== 1 || done_cyc[0] !== xf_acc[n - 1] + 4) begin n_fail++; $display("FAIL %s_done got n=%0d want 1 at %0d", tag, done_cyc.size(), xf_acc[n - 1] + 4); end
        end
    endtask

    task automatic test_range();
        run_cases("range", 5, 1'b0);
    endtask

    task automatic test_random_gaps();
        run_cases("rand", 8, 1'b1);
    endtask

    task automatic test_reset_mid();
        int acc;
        bit ok;
        do_reset();
        send_word(mk_hdr(8'hA5, 2, 3), acc, ok);
        send_word(32'hDEAD_BEEF, acc, ok);
        Reset = 1'b1;
        step();
        n_assert++; if (FrameStrobe !== '0 || Done !== 1'b0 || Busy !== 1'b0) begin n_fail++; $display("FAIL midreset_outputs got strobe=%h done=%b busy=%b want 0 0 0", FrameStrobe, Done, Busy); end
        Reset = 1'b0;
        step();
        n_assert++; if (WordReady !== 1'b1 || Busy !== 1'b0) begin n_fail++; $display("FAIL midreset_idle got ready=%b busy=%b want 1 0", WordReady, Busy); end
        repeat (3) step();
        n_assert++; if (ev_cyc.size() !== 0 || done_cyc.size() !== 0) begin n_fail++; $display("FAIL midreset_quiet got strobes=%0d dones=%0d want 0 0", ev_cyc.size(), done_cyc.size()); end
        xfer(5, 2, 0);
        repeat (6) step();
        n_assert++; if (ev_cyc.size() !== 2 || done_cyc.size() !== 1) begin n_fail++; $display("FAIL midreset_follow got strobes=%0d dones=%0d want 2 1", ev_cyc.size(), done_cyc.size()); end
        else begin
            n_assert++; if (ev_val[1] !== 20'h0_0040 || ev_data[1] !== xf_words[1]) begin n_fail++; $display("FAIL midreset_follow_data got %h/%h want 00040/%h", ev_val[1], ev_data[1], xf_words[1]); end
        end
    endtask

    task automatic test_back_to_back();
        int last_acc;
        logic [31:0] w0;
        do_reset();
        xfer(0, 2, 0);
        last_acc = xf_acc[1];
        w0       = xf_words[0];
        repeat (3) step();
        n_assert++; if (Done !== 1'b1 || WordReady !== 1'b1) begin n_fail++; $display("FAIL b2b_done_cycle got done=%b ready=%b want 1 1", Done, WordReady); end
        xfer(10, 3, 0);
        repeat (6) step();
        n_assert++; if (xf_hdr_acc !== last_acc + 4) begin n_fail++; $display("FAIL b2b_hdr_accept got %0d want %0d", xf_hdr_acc, last_acc + 4); end
        n_assert++; if (ev_cyc.size() !== 5 || done_cyc.size() !== 2) begin n_fail++; $display("FAIL b2b_counts got strobes=%0d dones=%0d want 5 2", ev_cyc.size(), done_cyc.size()); end
        else begin
            n_assert++; if (ev_data[0] !== w0 || ev_val[0] !== 20'h0_0001) begin n_fail++; $display("FAIL b2b_first got %h/%h want 00001/%h", ev_val[0], ev_data[0], w0); end
            n_assert++; if (ev_cyc[2] !== xf_acc[0] + 2 || ev_val[2] !== 20'h0_0400) begin n_fail++; $display("FAIL b2b_second_strobe got %0d/%h want %0d/00400", ev_cyc[2], ev_val[2], xf_acc[0] + 2); end
            n_assert++; if (ev_data[4] !== xf_words[2] || ev_val[4] !== 20'h0_1000) begin n_fail++; $display("FAIL b2b_last got %h/%h want 01000/%h", ev_val[4], ev_data[4], xf_words[2]); end
            n_assert++; if (done_cyc[1] !== xf_acc[2] + 4) begin n_fail++; $display("FAIL b2b_done2 got %0d want %0d", done_cyc[1], xf_acc[2] + 4); end
        end
    endtask

    initial begin
        Reset     = 1'b1;
        WordValid = 1'b0;
        WordIn    = 32'd0;
        test_reset();
        test_basic();
        test_bad_sync();
        test_range();
        test_random_gaps();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
